// File: rtl/sap2_ctrl_pkg.sv
// Shared constants for the SAP-2 control sequencer: control-word bit positions,
// opcodes, one-hot T-states and the per-opcode end-state table.
package sap2_ctrl_pkg;

    localparam int CW_W = 12;
    localparam int T_W  = 18;

    localparam int CW_EP  = 0;
    localparam int CW_LM  = 1;
    localparam int CW_CP  = 2;
    localparam int CW_CE  = 3;
    localparam int CW_LI  = 4;
    localparam int CW_LA  = 5;
    localparam int CW_EB  = 6;
    localparam int CW_EU  = 7;
    localparam int CW_SU  = 8;
    localparam int CW_LPL = 9;
    localparam int CW_LPH = 10;
    localparam int CW_HLT = 11;

    localparam logic [CW_W-1:0] M_EP  = CW_W'(1) << CW_EP;
    localparam logic [CW_W-1:0] M_LM  = CW_W'(1) << CW_LM;
    localparam logic [CW_W-1:0] M_CP  = CW_W'(1) << CW_CP;
    localparam logic [CW_W-1:0] M_CE  = CW_W'(1) << CW_CE;
    localparam logic [CW_W-1:0] M_LI  = CW_W'(1) << CW_LI;
    localparam logic [CW_W-1:0] M_LA  = CW_W'(1) << CW_LA;
    localparam logic [CW_W-1:0] M_EB  = CW_W'(1) << CW_EB;
    localparam logic [CW_W-1:0] M_EU  = CW_W'(1) << CW_EU;
    localparam logic [CW_W-1:0] M_SU  = CW_W'(1) << CW_SU;
    localparam logic [CW_W-1:0] M_LPL = CW_W'(1) << CW_LPL;
    localparam logic [CW_W-1:0] M_LPH = CW_W'(1) << CW_LPH;
    localparam logic [CW_W-1:0] M_HLT = CW_W'(1) << CW_HLT;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_MOV_AB = 8'h78;
    localparam logic [7:0] OP_ADD_B  = 8'h80;
    localparam logic [7:0] OP_SUB_B  = 8'h90;
    localparam logic [7:0] OP_MVI_A  = 8'h3E;
    localparam logic [7:0] OP_JMP    = 8'hC3;
    localparam logic [7:0] OP_JZ     = 8'hCA;
    localparam logic [7:0] OP_HLT    = 8'h76;

    localparam logic [T_W-1:0] T01 = 18'h00001;
    localparam logic [T_W-1:0] T02 = 18'h00002;
    localparam logic [T_W-1:0] T03 = 18'h00004;
    localparam logic [T_W-1:0] T04 = 18'h00008;
    localparam logic [T_W-1:0] T05 = 18'h00010;
    localparam logic [T_W-1:0] T06 = 18'h00020;
    localparam logic [T_W-1:0] T07 = 18'h00040;
    localparam logic [T_W-1:0] T08 = 18'h00080;
    localparam logic [T_W-1:0] T09 = 18'h00100;

    typedef enum logic [1:0] {
        MODE_RUN,
        MODE_HALT,
        MODE_ERR
    } mode_t;

    // Zero-based ring index of the last T-state of each instruction.
    function automatic logic [4:0] end_index(input logic [7:0] op, input logic zq);
        case (op)
            OP_MVI_A: end_index = 5'd5;
            OP_JMP:   end_index = 5'd8;
            OP_JZ:    end_index = zq ? 5'd8 : 5'd4;
            default:  end_index = 5'd3;
        endcase
    endfunction

    function automatic logic is_legal(input logic [7:0] op);
        case (op)
            OP_NOP, OP_MOV_AB, OP_ADD_B, OP_SUB_B,
            OP_MVI_A, OP_JMP, OP_JZ, OP_HLT: is_legal = 1'b1;
            default:                         is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sap2_ctrl_decode.sv
// Purely combinational decode of (T-state, opcode, latched zero flag) into the
// raw control word plus end-of-instruction, legality and range indications.
module sap2_ctrl_decode
    import sap2_ctrl_pkg::*;
(
    input  logic [T_W-1:0]  state,
    input  logic [7:0]      opcode,
    input  logic            zero_q,
    output logic [CW_W-1:0] cw_raw,
    output logic            last,
    output logic            legal,
    output logic            in_range
);

    logic [4:0]      end_idx;
    logic [T_W-1:0]  end_state;
    logic [T_W-1:0]  range_mask;
    logic [CW_W-1:0] jmp_cw;

    always_comb begin
        end_idx    = end_index(opcode, zero_q);
        end_state  = T_W'(1) << end_idx;
        range_mask = (end_state << 1) - T_W'(1);
        last       = (state == end_state);
        in_range   = ((state & ~range_mask) == '0);
        legal      = is_legal(opcode);
    end

    // Operand fetch of a 16-bit address: low byte to PC-low, then high byte to PC-high.
    always_comb begin
        jmp_cw = '0;
        case (state)
            T04:     jmp_cw = M_EP | M_LM;
            T05:     jmp_cw = M_CP;
            T06:     jmp_cw = M_CE | M_LPL;
            T07:     jmp_cw = M_EP | M_LM;
            T08:     jmp_cw = M_CP;
            T09:     jmp_cw = M_CE | M_LPH;
            default: jmp_cw = '0;
        endcase
    end

    always_comb begin
        cw_raw = '0;
        case (state)
            T01: cw_raw = M_EP | M_LM;
            T02: cw_raw = M_CP;
            T03: cw_raw = M_CE | M_LI;
            default: begin
                case (opcode)
                    OP_MOV_AB: if (state == T04) cw_raw = M_EB | M_LA;
                    OP_ADD_B:  if (state == T04) cw_raw = M_EU | M_LA;
                    OP_SUB_B:  if (state == T04) cw_raw = M_SU | M_EU | M_LA;
                    OP_HLT:    if (state == T04) cw_raw = M_HLT;
                    OP_MVI_A: begin
                        if (state == T04)      cw_raw = M_EP | M_LM;
                        else if (state == T05) cw_raw = M_CP;
                        else if (state == T06) cw_raw = M_CE | M_LA;
                    end
                    OP_JMP: cw_raw = jmp_cw;
                    // Untaken branch still steps PC past both address bytes.
                    OP_JZ: begin
                        if (zero_q)                            cw_raw = jmp_cw;
                        else if (state == T04 || state == T05) cw_raw = M_CP;
                    end
                    default: cw_raw = '0;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/sap2_controller.sv
// SAP-2 control sequencer: gates the decoded control word, drives the ring
// counter clear and keeps halt/error/illegal status and the retired count.
module sap2_controller
    import sap2_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [T_W-1:0]   state,
    input  logic [7:0]       opcode,
    input  logic             zero,
    output logic [CW_W-1:0]  cw,
    output logic             ring_nclr,
    output logic             run,
    output logic             illegal,
    output logic             err,
    output logic [CNT_W-1:0] instr_cnt
);

    mode_t           mode;
    mode_t           mode_next;
    logic            zero_q;
    logic [CW_W-1:0] cw_raw;
    logic            last;
    logic            legal;
    logic            in_range;
    logic            onehot;
    logic            bad;

    sap2_ctrl_decode u_decode (
        .state    (state),
        .opcode   (opcode),
        .zero_q   (zero_q),
        .cw_raw   (cw_raw),
        .last     (last),
        .legal    (legal),
        .in_range (in_range)
    );

    always_comb begin
        onehot = (state != '0) && ((state & (state - T_W'(1))) == '0);
        bad    = !onehot || !in_range;
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) mode <= MODE_RUN;
        else     mode <= mode_next;
    end

    // A desync on the same edge as HLT's last T-state takes priority over halting.
    always_comb begin
        mode_next = mode;
        case (mode)
            MODE_RUN: begin
                if (bad)
                    mode_next = MODE_ERR;
                else if (last && state == T04 && opcode == OP_HLT)
                    mode_next = MODE_HALT;
            end
            default: mode_next = mode;
        endcase
    end

    always_comb begin
        cw        = '0;
        ring_nclr = 1'b1;
        run       = 1'b1;
        err       = (mode == MODE_ERR);
        if (!CLR) begin
            case (mode)
                MODE_RUN: begin
                    cw        = cw_raw;
                    ring_nclr = !last;
                end
                default: begin
                    ring_nclr = 1'b0;
                    run       = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            zero_q    <= 1'b0;
            illegal   <= 1'b0;
            instr_cnt <= '0;
        end else if (mode == MODE_RUN && !bad) begin
            if (state == T03)
                zero_q <= zero;
            if (state == T04 && !legal)
                illegal <= 1'b1;
            if (last)
                instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sap2_controller.sv
// Randomized self-checking bench for sap2_controller; acts as the ring counter
// and compares against an instruction-level model of the micro-sequences.
module tb_sap2_controller;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic [17:0] state = '0;
    logic [7:0]  opcode = '0;
    logic        zero = 1'b0;

    logic [11:0] cw, cw_s;
    logic        ring_nclr, ring_nclr_s, run, run_s;
    logic        illegal, illegal_s, err, err_s;
    logic [15:0] instr_cnt;
    logic [3:0]  instr_cnt_s;

    int          n_vec = 0;
    int          n_bad = 0;
    logic        m_zq, m_halted, m_err, m_illegal;
    int unsigned m_cnt;
    logic [11:0] seq[$];

    sap2_controller dut (
        .CLK(CLK), .CLR(CLR), .state(state), .opcode(opcode), .zero(zero),
        .cw(cw), .ring_nclr(ring_nclr), .run(run), .illegal(illegal),
        .err(err), .instr_cnt(instr_cnt)
    );

    // Narrow counter instance so counter wrap is reachable in a short run.
    sap2_controller #(.CNT_W(4)) dut_s (
        .CLK(CLK), .CLR(CLR), .state(state), .opcode(opcode), .zero(zero),
        .cw(cw_s), .ring_nclr(ring_nclr_s), .run(run_s), .illegal(illegal_s),
        .err(err_s), .instr_cnt(instr_cnt_s)
    );

    always #5 CLK = ~CLK;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit op_known(input logic [7:0] op);
        return op inside {8'h00, 8'h78, 8'h80, 8'h90, 8'h3E, 8'hC3, 8'hCA, 8'h76};
    endfunction

    // Full instruction as a list of control words, one per T-state from T01.
    task automatic build_seq(input logic [7:0] op, input logic zq);
        seq = '{12'h003, 12'h004, 12'h018};
        case (op)
            8'h78: seq.push_back(12'h060);
            8'h80: seq.push_back(12'h0A0);
            8'h90: seq.push_back(12'h1A0);
            8'h76: seq.push_back(12'h800);
            8'h3E: seq = {seq, 12'h003, 12'h004, 12'h028};
            8'hC3: seq = {seq, 12'h003, 12'h004, 12'h208, 12'h003, 12'h004, 12'h408};
            8'hCA: if (zq) seq = {seq, 12'h003, 12'h004, 12'h208, 12'h003, 12'h004, 12'h408};
                   else    seq = {seq, 12'h004, 12'h004};
            default: seq.push_back(12'h000);
        endcase
    endtask

    task automatic apply_stimulus(input logic [17:0] st, input logic [7:0] op, input logic z);
        int t;
        int end_t;
        bit stopped;
        bit bad;
        state  = st;
        opcode = op;
        zero   = z;
        @(negedge CLK);
        build_seq(op, m_zq);
        end_t = seq.size() - 1;
        t = 0;
        for (int i = 0; i < 18; i++) if (st[i]) t = i;
        stopped = m_halted || m_err;
        bad = ($countones(st) != 1) || (t > end_t);
        if (stopped) begin
            check_output("cw_stopped", 32'(cw), 32'h0);
            check_output("nclr_stopped", 32'(ring_nclr), 32'h0);
            check_output("run_stopped", 32'(run), 32'h0);
            check_output("run_stopped_s", 32'(run_s), 32'h0);
        end else begin
            check_output("run", 32'(run), 32'h1);
            if (!bad) begin
                check_output("cw", 32'(cw), 32'(seq[t]));
                check_output("cw_s", 32'(cw_s), 32'(seq[t]));
                check_output("nclr", 32'(ring_nclr), (t == end_t) ? 32'h0 : 32'h1);
                check_output("nclr_s", 32'(ring_nclr_s), (t == end_t) ? 32'h0 : 32'h1);
            end
        end
        @(posedge CLK);
        if (!stopped) begin
            if (bad) m_err = 1'b1;
            else begin
                if (t == 2) m_zq = z;
                if (t == 3 && !op_known(op)) m_illegal = 1'b1;
                if (t == 3 && op == 8'h76) m_halted = 1'b1;
                if (t == end_t) m_cnt++;
            end
        end
        #1;
        check_output("illegal", 32'(illegal), 32'(m_illegal));
        check_output("err", 32'(err), 32'(m_err));
        check_output("err_s", 32'(err_s), 32'(m_err));
        check_output("instr_cnt", 32'(instr_cnt), 32'(m_cnt[15:0]));
        check_output("instr_cnt_s", 32'(instr_cnt_s), 32'(m_cnt[3:0]));
    endtask

    task automatic run_instr(input logic [7:0] op, input logic z3, input bit overrun);
        int t = 0;
        int last_t = 2;
        while (t <= last_t && !(m_halted || m_err)) begin
            apply_stimulus(18'(1) << t, (t < 3) ? 8'($urandom) : op, (t == 2) ? z3 : 1'($urandom));
            if (t == 2) begin
                build_seq(op, m_zq);
                last_t = seq.size() - 1;
            end
            t++;
        end
        if (overrun && !(m_halted || m_err))
            apply_stimulus(18'(1) << t, op, 1'($urandom));
    endtask

    task automatic park(input int n);
        repeat (n) apply_stimulus(18'h1, 8'($urandom), 1'($urandom));
    endtask

    task automatic do_reset();
        CLR = 1'b1;
        #2;
        check_output("rst_cw", 32'(cw), 32'h0);
        check_output("rst_nclr", 32'(ring_nclr), 32'h1);
        check_output("rst_run", 32'(run), 32'h1);
        check_output("rst_illegal", 32'(illegal), 32'h0);
        check_output("rst_err", 32'(err), 32'h0);
        check_output("rst_cnt", 32'(instr_cnt), 32'h0);
        check_output("rst_cnt_s", 32'(instr_cnt_s), 32'h0);
        @(posedge CLK);
        #1;
        CLR = 1'b0;
        m_zq = 1'b0; m_halted = 1'b0; m_err = 1'b0; m_illegal = 1'b0; m_cnt = 0;
    endtask

    initial begin
        logic [7:0]  op;
        logic [17:0] junk;
        int          r;
        @(posedge CLK);
        #1;
        do_reset();

        run_instr(8'h00, 1'b0, 1'b0);
        run_instr(8'h80, 1'b0, 1'b0);
        run_instr(8'h3E, 1'b0, 1'b0);
        check_output("three_retired", 32'(instr_cnt), 32'd3);

        run_instr(8'hCA, 1'b1, 1'b0);
        run_instr(8'hCA, 1'b0, 1'b0);

        run_instr(8'h76, 1'b0, 1'b0);
        park(20);
        check_output("halt_count", 32'(instr_cnt), 32'd6);
        do_reset();

        run_instr(8'hFF, 1'b0, 1'b0);
        check_output("illegal_run", 32'(run), 32'h1);

        apply_stimulus(18'h00003, 8'h00, 1'b0);
        park(2);
        do_reset();

        run_instr(8'h80, 1'b0, 1'b1);
        park(2);
        do_reset();

        for (int t = 0; t < 7; t++)
            apply_stimulus(18'(1) << t, 8'hC3, 1'b0);
        do_reset();

        repeat (20) run_instr(8'h00, 1'b0, 1'b0);

        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                run_instr(8'h76, 1'($urandom), 1'b0);
            end else if (r < 4) begin
                do junk = 18'($urandom); while ($countones(junk) == 1);
                apply_stimulus(junk, 8'($urandom), 1'($urandom));
            end else if (r < 6) begin
                op = 8'($urandom);
                run_instr(op, 1'($urandom), 1'b1);
            end else if (r < 12) begin
                do op = 8'($urandom); while (op_known(op));
                run_instr(op, 1'($urandom), 1'b0);
            end else begin
                case ($urandom_range(0, 6))
                    0: op = 8'h00;
                    1: op = 8'h78;
                    2: op = 8'h80;
                    3: op = 8'h90;
                    4: op = 8'h3E;
                    5: op = 8'hC3;
                    default: op = 8'hCA;
                endcase
                run_instr(op, 1'($urandom), 1'b0);
            end
            if (m_halted || m_err) begin
                park($urandom_range(1, 5));
                do_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
